// File: rtl/attn_pkg.sv
// attn_pkg: shared constants and FSM state type for the attention feed path.
package attn_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned SEQ_LEN     = 30;
    localparam int unsigned STEP_W      = 5;
    localparam int unsigned BLOCK_SEL_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STREAM   = 3'd1,
        ST_GAP      = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_DONE     = 3'd4
    } attn_state_e;

endpackage

// File: rtl/attn_seq_buf.sv
// attn_seq_buf: DEPTH x DW register file, one write port, one registered
// read port; the whole array and the read register clear on reset.
module attn_seq_buf
    import attn_pkg::*;
#(
    parameter int unsigned DEPTH = SEQ_LEN,
    parameter int unsigned DW    = DATA_W,
    parameter int unsigned AW    = STEP_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Storage array: cleared on reset, written on in-range write strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read: the output holds its last word while rd_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en && (32'(rd_addr) < DEPTH)) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/attn_seq_feeder.sv
// attn_seq_feeder: buffers one SEQ_LEN-step sequence written by the host,
// streams it word by word to the attention block with a held block_sel,
// then waits for the block's completion pulse and reports done.
// Optional feature macro ATTN_FEED_TIMEOUT_EN: builds a WAIT_RSP timeout
// that sets the sticky err flag and returns to IDLE without done.
module attn_seq_feeder
    import attn_pkg::*;
#(
    parameter int unsigned GAP = 0
`ifdef ATTN_FEED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [STEP_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   start,
    input  logic [BLOCK_SEL_W-1:0] block_sel_in,
    input  logic                   attn_done,
    output logic                   ready,
    output logic                   busy,
    output logic [DATA_W-1:0]      data_out,
    output logic                   data_out_valid,
    output logic [BLOCK_SEL_W-1:0] block_sel,
    output logic [STEP_W-1:0]      step,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned       GAP_CW   = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [GAP_CW-1:0] GAP_LAST = (GAP > 0) ? GAP_CW'(GAP - 1) : '0;
    localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(SEQ_LEN - 1);

    attn_state_e       state;
    logic [STEP_W-1:0] idx;
    logic [GAP_CW-1:0] gap_cnt;
    logic              buf_we;
    logic              buf_re;

`ifdef ATTN_FEED_TIMEOUT_EN
    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign err = 1'b0;
`endif

    // Host writes land only while idle; the start cycle still counts as idle,
    // so a write issued with start is committed before the first read.
    assign buf_we = wr_en && (state == ST_IDLE) && (32'(wr_addr) < SEQ_LEN);
    assign buf_re = (state == ST_STREAM);

    // The buffer's registered read port is data_out itself, so the word
    // holds through GAP and WAIT_RSP without an extra register.
    attn_seq_buf #(
        .DEPTH (SEQ_LEN),
        .DW    (DATA_W),
        .AW    (STEP_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (buf_re),
        .rd_addr (idx),
        .rd_data (data_out)
    );

    // Sequencer FSM with registered status and stream-control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            gap_cnt        <= '0;
            ready          <= 1'b1;
            busy           <= 1'b0;
            data_out_valid <= 1'b0;
            block_sel      <= '0;
            step           <= '0;
            done           <= 1'b0;
`ifdef ATTN_FEED_TIMEOUT_EN
            to_cnt         <= '0;
            err            <= 1'b0;
`endif
        end else begin
            data_out_valid <= 1'b0;
            done           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        block_sel <= block_sel_in;
                        idx       <= '0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    step           <= idx;
                    data_out_valid <= 1'b1;
                    if (idx == LAST_IDX) begin
`ifdef ATTN_FEED_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        state  <= ST_WAIT_RSP;
                    end else if (GAP > 0) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        idx   <= idx + 1'b1;
                        state <= ST_STREAM;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_WAIT_RSP: begin
                    if (attn_done) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
`ifdef ATTN_FEED_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        err   <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_attn_seq_feeder.sv
// tb_attn_seq_feeder: scoreboard bench for attn_seq_feeder. Instance 0 streams
// back-to-back (GAP=0), instance 1 uses GAP=2. Only one instance is active at
// a time, so a single expected-word queue and a single done queue serve both.
module tb_attn_seq_feeder;

    localparam int NS = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        wr_en     [2];
    logic [4:0]  wr_addr   [2];
    logic [15:0] wr_data   [2];
    logic        start     [2];
    logic [2:0]  bsel_in   [2];
    logic        attn_done [2];
    logic        ready_o   [2];
    logic        busy_o    [2];
    logic [15:0] dout      [2];
    logic        dov       [2];
    logic [2:0]  bsel_o    [2];
    logic [4:0]  step_o    [2];
    logic        done_o    [2];
    logic        err_o     [2];

    attn_seq_feeder #(
        .GAP (0)
`ifdef ATTN_FEED_TIMEOUT_EN
        , .TIMEOUT_CYC (16)
`endif
    ) u_dut0 (
        .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .start(start[0]), .block_sel_in(bsel_in[0]),
        .attn_done(attn_done[0]), .ready(ready_o[0]), .busy(busy_o[0]),
        .data_out(dout[0]), .data_out_valid(dov[0]), .block_sel(bsel_o[0]),
        .step(step_o[0]), .done(done_o[0]), .err(err_o[0])
    );

    attn_seq_feeder #(
        .GAP (2)
`ifdef ATTN_FEED_TIMEOUT_EN
        , .TIMEOUT_CYC (16)
`endif
    ) u_dut1 (
        .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .start(start[1]), .block_sel_in(bsel_in[1]),
        .attn_done(attn_done[1]), .ready(ready_o[1]), .busy(busy_o[1]),
        .data_out(dout[1]), .data_out_valid(dov[1]), .block_sel(bsel_o[1]),
        .step(step_o[1]), .done(done_o[1]), .err(err_o[1])
    );

    // Reference model state
    logic [15:0] mdl [2][NS];
    bit          err_m [2];

    typedef struct {
        int          d;
        logic [15:0] data;
        logic [4:0]  step;
        logic [2:0]  bsel;
    } exp_t;
    typedef struct {
        int     d;
        longint cyc;
    } dexp_t;

    exp_t   exp_q [$];
    dexp_t  done_q [$];
    longint start_edge [2];
    longint first_v [2];
    longint last_v [2];

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gapv(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int d);
        chk("rst_ready", ready_o[d], 1'b1);
        chk("rst_busy", busy_o[d], 1'b0);
        chk("rst_data_out", dout[d], 16'h0);
        chk("rst_valid", dov[d], 1'b0);
        chk("rst_block_sel", bsel_o[d], 3'd0);
        chk("rst_step", step_o[d], 5'd0);
        chk("rst_done", done_o[d], 1'b0);
        chk("rst_err", err_o[d], 1'b0);
    endtask

    // Monitor: pops an expectation for every valid word and every done pulse.
    always @(negedge clk) begin : mon
        exp_t  e;
        dexp_t de;
        for (int d = 0; d < 2; d++) begin
            if (dov[d] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: dut%0d actual=valid step=%0d required=idle", d, step_o[d]);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_dut", d, e.d);
                    chk("data_out", dout[d], e.data);
                    chk("step", step_o[d], e.step);
                    chk("block_sel", bsel_o[d], e.bsel);
                    if (e.step == 5'd0) begin
                        chk("first_latency", cyc - start_edge[d], 1);
                        first_v[d] = cyc;
                    end else begin
                        chk("word_spacing", cyc - last_v[d], 1 + gapv(d));
                    end
                    last_v[d] = cyc;
                end
            end
            if (done_o[d] === 1'b1) begin
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: dut%0d actual=done required=no done", d);
                end else begin
                    de = done_q.pop_front();
                    chk("done_dut", d, de.d);
                    chk("done_cycle", cyc, de.cyc);
                end
            end
        end
    end

    // Host write; the model keeps in-range words (bench writes only while idle).
    task automatic wr(input int d, input int addr, input logic [15:0] data);
        wr_en[d]   = 1'b1;
        wr_addr[d] = 5'(addr);
        wr_data[d] = data;
        if (addr < NS) mdl[d][addr] = data;
        tick();
        wr_en[d] = 1'b0;
    endtask

    // One transaction. rsp_delay < 0: no attn_done (timeout). rst_at >= 0:
    // reset while word rst_at is on the output.
    task automatic run(input int d, input logic [2:0] bsel, input bit wr_same,
                       input bit disturb, input int rsp_delay, input int rst_at);
        longint n;
        longint e_edge;
        longint t;
        int     g;
        g = gapv(d);
        start[d]   = 1'b1;
        bsel_in[d] = bsel;
        if (wr_same) begin
            wr_en[d]   = 1'b1;
            wr_addr[d] = 5'($urandom_range(0, NS - 1));
            wr_data[d] = 16'($urandom);
            mdl[d][wr_addr[d]] = wr_data[d];
        end
        for (int i = 0; i < NS; i++) exp_q.push_back('{d, mdl[d][i], 5'(i), bsel});
        n = cyc + 1;
        start_edge[d] = n;
        e_edge = n + 1 + (NS - 1) * (1 + g);
        tick();
        start[d] = 1'b0;
        wr_en[d] = 1'b0;
        if (disturb) begin
            while (cyc < n + 3) tick();
            start[d]     = 1'b1;
            bsel_in[d]   = ~bsel;
            wr_en[d]     = 1'b1;
            wr_addr[d]   = 5'd3;
            wr_data[d]   = 16'hDEAD;
            attn_done[d] = 1'b1;
            tick();
            start[d]     = 1'b0;
            wr_en[d]     = 1'b0;
            attn_done[d] = 1'b0;
        end
        if (rst_at >= 0) begin
            while (cyc < n + 1 + rst_at * (1 + g)) tick();
            rst[d] = 1'b1;
            exp_q.delete();
            done_q.delete();
            for (int i = 0; i < NS; i++) mdl[d][i] = '0;
            err_m[d] = 1'b0;
            #1;
            chk_reset(d);
            tick();
            rst[d] = 1'b0;
            return;
        end
        if (rsp_delay >= 0) begin
            t = e_edge + rsp_delay;
            while (cyc < t) tick();
            attn_done[d] = 1'b1;
            done_q.push_back('{d, t + 1});
            tick();
            attn_done[d] = 1'b0;
            tick();
            chk("ready_after_done", ready_o[d], 1'b1);
            chk("busy_after_done", busy_o[d], 1'b0);
            chk("done_outstanding", done_q.size(), 0);
        end else begin
            while (cyc < e_edge + 15) tick();
            chk("ready_before_timeout", ready_o[d], 1'b0);
            tick();
            chk("ready_at_timeout", ready_o[d], 1'b1);
            err_m[d] = 1'b1;
        end
        chk("words_outstanding", exp_q.size(), 0);
        chk("err", err_o[d], err_m[d]);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; wr_en[d] = 1'b0; wr_addr[d] = '0; wr_data[d] = '0;
            start[d] = 1'b0; bsel_in[d] = '0; attn_done[d] = 1'b0; err_m[d] = 1'b0;
            first_v[d] = 0; last_v[d] = 0; start_edge[d] = 0;
            for (int i = 0; i < NS; i++) mdl[d][i] = '0;
        end
        repeat (3) tick();
        chk_reset(0);
        chk_reset(1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();

        // Ramp data, block_sel 5, completion 10 cycles into WAIT_RSP
        for (int i = 0; i < NS; i++) wr(0, i, 16'h0100 + 16'(i));
        run(0, 3'd5, 1'b0, 1'b0, 10, -1);

        // Out-of-range writes, then a run disturbed by a write, start and attn_done
        // mid-stream; completion arrives the cycle WAIT_RSP is entered
        wr(0, 30, 16'hBEEF);
        wr(0, 31, 16'hCAFE);
        run(0, 3'd2, 1'b0, 1'b1, 0, -1);
        run(0, 3'd6, 1'b0, 1'b0, 3, -1);

        // Reset at step 12, then the cleared buffer streams zeros
        run(0, 3'd7, 1'b0, 1'b0, 0, 12);
        run(0, 3'd1, 1'b0, 1'b0, 2, -1);

        // Randomized writes, block selects and completion delays
        for (int k = 0; k < 6; k++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int j = 0; j < nw; j++) wr(0, $urandom_range(0, 31), 16'($urandom));
            run(0, 3'($urandom), (k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0,
                $urandom_range(0, 6), -1);
        end

        // GAP=2 instance: 30 words spaced 3 cycles apart, 88 cycles first to last
        for (int i = 0; i < NS; i++) wr(1, i, 16'h0100 + 16'(i));
        run(1, 3'd5, 1'b0, 1'b0, 4, -1);
        chk("gap_span", last_v[1] - first_v[1] + 1, 88);

`ifdef ATTN_FEED_TIMEOUT_EN
        run(0, 3'd4, 1'b0, 1'b0, -1, -1);
        run(0, 3'd3, 1'b0, 1'b0, 5, -1);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
